// File: rtl/led_strip_rx_if.sv
// Purpose: valid/ready stream carrying one received LED word and its position.
// Latency: none, wires only.
// Backpressure: the master holds the word while led_valid=1 and led_ready=0.
interface led_strip_rx_if;
  logic        led_valid;
  logic        led_ready;
  logic [31:0] led_word;
  logic [5:0]  led_index;

  modport master (output led_valid, output led_word, output led_index, input led_ready);
  modport slave  (input led_valid, input led_word, input led_index, output led_ready);
endinterface

// File: rtl/led_strip_rx.sv
// Purpose: deserialise an APA102-style LED strip stream into 32-bit LED words.
// Latency: led_valid rises 3 clk edges after c1 first samples the last strip_clk fall.
// Backpressure: one-word holding register; a word arriving while it is full and not
//   being accepted is dropped and flagged on the sticky overrun output.
module led_strip_rx #(
  parameter int NUM_LEDS     = 64,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           strip_clk,
  input  logic           strip_data,
  led_strip_rx_if.master led,
  output logic           frame_done,
  output logic           frame_error,
  output logic           overrun
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  logic              c1, c2, c3, d1, d2, d3;
  logic              bit_stb, bit_val;
  logic [1:0]        state;
  logic [5:0]        zero_cnt;
  logic [4:0]        bit_cnt;
  logic [31:0]       shreg;
  logic [6:0]        led_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [31:0]       word_next;

  // Word as it would stand once the current bit is shifted in.
  assign word_next = {shreg[30:0], bit_val};

  // Synchronise the strip lines; the falling-edge strobe and its data bit are
  // registered once more so the FSM sees a clean single-cycle bit event.
  always_ff @(posedge clk) begin
    if (reset) begin
      c1 <= 1'b0; c2 <= 1'b0; c3 <= 1'b0;
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
      bit_stb <= 1'b0;
      bit_val <= 1'b0;
    end else begin
      c1 <= strip_clk;  c2 <= c1; c3 <= c2;
      d1 <= strip_data; d2 <= d1; d3 <= d2;
      bit_stb <= ~c2 & c3;
      bit_val <= d3;
    end
  end

  // Framing FSM, output holding register, idle watchdog and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      zero_cnt      <= 6'd0;
      bit_cnt       <= 5'd0;
      shreg         <= 32'd0;
      led_cnt       <= 7'd0;
      idle_cnt      <= '0;
      led.led_valid <= 1'b0;
      led.led_word  <= 32'd0;
      led.led_index <= 6'd0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (led.led_valid && led.led_ready) begin
        led.led_valid <= 1'b0;
      end

      if (bit_stb) begin
        idle_cnt <= '0;
        case (state)
          HUNT: begin
            if (bit_val) begin
              zero_cnt <= 6'd0;
            end else if (zero_cnt == 6'd31) begin
              state       <= SYNC;
              frame_error <= 1'b0;
              led_cnt     <= 7'd0;
              zero_cnt    <= 6'd0;
            end else if (zero_cnt != 6'h3f) begin
              zero_cnt <= zero_cnt + 6'd1;
            end
          end
          SYNC: begin
            // Every LED word starts with a 1, so zeros here are padding.
            if (bit_val) begin
              state   <= WORD;
              shreg   <= 32'd1;
              bit_cnt <= 5'd1;
            end
          end
          WORD: begin
            if (bit_cnt != 5'd31) begin
              shreg   <= word_next;
              bit_cnt <= bit_cnt + 5'd1;
            end else if (word_next[31:29] != 3'b111) begin
              frame_error <= 1'b1;
              state       <= HUNT;
              zero_cnt    <= 6'd0;
            end else begin
              if (!led.led_valid || led.led_ready) begin
                led.led_word  <= word_next;
                led.led_index <= led_cnt[5:0];
                led.led_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              led_cnt <= led_cnt + 7'd1;
              if (led_cnt == 7'(NUM_LEDS - 1)) begin
                frame_done <= 1'b1;
                state      <= HUNT;
                zero_cnt   <= 6'd0;
              end else begin
                state <= SYNC;
              end
            end
          end
          default: begin
            state    <= HUNT;
            zero_cnt <= 6'd0;
          end
        endcase
      end else if (state != HUNT) begin
        if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          frame_error <= 1'b1;
          state       <= HUNT;
          zero_cnt    <= 6'd0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_strip_rx.sv
// Purpose: self-checking bench for led_strip_rx (table vectors + scoreboard).
// Latency: checks the 3-edge strip_clk-fall to led_valid path explicitly.
// Backpressure: exercises led_ready held low to provoke overrun.
module tb_led_strip_rx;
  localparam int NUM_LEDS = 64;
  localparam int IDLE     = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic strip_clk = 1'b0;
  logic strip_data = 1'b0;
  logic frame_done, frame_error, overrun;

  led_strip_rx_if led_if ();

  led_strip_rx #(.NUM_LEDS(NUM_LEDS), .IDLE_TIMEOUT(IDLE)) dut (
    .clk(clk), .reset(reset), .strip_clk(strip_clk), .strip_data(strip_data),
    .led(led_if.master), .frame_done(frame_done), .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  idx;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    bit          emit;
    bit          err;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [5:0] done_idx = 6'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (led_if.led_valid && led_if.led_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h idx=%0d required=none",
                   led_if.led_word, led_if.led_index);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_word", led_if.led_word, e.word);
          chk("sb_index", {26'd0, led_if.led_index}, {26'd0, e.idx});
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_idx = led_if.led_index;
      end
    end
  end

  task automatic send_bit(input logic b);
    strip_data = b;
    strip_clk  = 1'b1;
    repeat (4) @(negedge clk);
    strip_clk  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic push(input logic [31:0] w, input logic [5:0] idx);
    exp_t e;
    e.word = w;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic gap();
    repeat (IDLE + 20) @(negedge clk);
  endtask

  vec_t vecs[5];
  logic [31:0] lw;

  initial begin
    vecs[0] = '{word: 32'hF0000F00, emit: 1'b1, err: 1'b0};
    vecs[1] = '{word: 32'hFF00FF00, emit: 1'b1, err: 1'b0};
    vecs[2] = '{word: 32'hBF000000, emit: 1'b0, err: 1'b1};
    vecs[3] = '{word: 32'hE1234567, emit: 1'b1, err: 1'b0};
    vecs[4] = '{word: 32'hDEADBEEF, emit: 1'b0, err: 1'b1};

    led_if.led_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, led_if.led_valid}, 32'd0);
    chk("rst_word", led_if.led_word, 32'd0);
    chk("rst_index", {26'd0, led_if.led_index}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, frame_error}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

    // Table: start frame + one word, then let the watchdog return to HUNT.
    for (int v = 0; v < 5; v++) begin
      send_zeros(32);
      if (vecs[v].emit) push(vecs[v].word, 6'd0);
      send_word(vecs[v].word);
      repeat (6) @(negedge clk);
      chk("vec_err", {31'd0, frame_error}, {31'd0, vecs[v].err});
      chk("vec_drained", sb.size(), 32'd0);
      gap();
      chk("vec_err_after_gap", {31'd0, frame_error}, 32'd1);
    end

    // Latency: last falling strip_clk edge to led_valid takes 3 clk edges.
    send_zeros(32);
    lw = 32'hF0000F00;
    for (int i = 31; i >= 1; i--) send_bit(lw[i]);
    push(lw, 6'd0);
    strip_data = lw[0];
    strip_clk  = 1'b1;
    repeat (4) @(negedge clk);
    strip_clk  = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_not_yet", {31'd0, led_if.led_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, led_if.led_valid}, 32'd1);
    repeat (4) @(negedge clk);
    chk("lat_err", {31'd0, frame_error}, 32'd0);
    gap();

    // Word with a zero MSB: its leading 0 is padding, the rest never completes.
    send_zeros(32);
    chk("start_clears_err", {31'd0, frame_error}, 32'd0);
    send_word(32'h70000000);
    gap();
    chk("msb0_err", {31'd0, frame_error}, 32'd1);
    chk("msb0_nothing", sb.size(), 32'd0);
    send_zeros(32);
    chk("msb0_cleared", {31'd0, frame_error}, 32'd0);
    gap();

    // Full update of NUM_LEDS words with ready high, plus end-frame zeros.
    send_zeros(40);
    for (int i = 0; i < NUM_LEDS; i++) begin
      push(32'hF0070000, 6'(i));
      send_word(32'hF0070000);
    end
    send_zeros(32);
    chk("full_drained", sb.size(), 32'd0);
    chk("full_done_cnt", done_cnt, 32'd1);
    chk("full_done_idx", {26'd0, done_idx}, 32'd63);
    chk("full_err", {31'd0, frame_error}, 32'd0);
    chk("full_ovr", {31'd0, overrun}, 32'd0);
    gap();

    // Consumer stalled: second word is dropped, first held.
    led_if.led_ready = 1'b0;
    send_zeros(32);
    push(32'hE1000001, 6'd0);
    send_word(32'hE1000001);
    send_word(32'hE1000002);
    repeat (6) @(negedge clk);
    chk("ovr_valid", {31'd0, led_if.led_valid}, 32'd1);
    chk("ovr_word", led_if.led_word, 32'hE1000001);
    chk("ovr_index", {26'd0, led_if.led_index}, 32'd0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    led_if.led_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drained", sb.size(), 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    gap();

    // Strip clock stalls mid-word: watchdog aborts, nothing emitted.
    send_zeros(32);
    lw = 32'hFFFFFFFF;
    for (int i = 31; i >= 22; i--) send_bit(lw[i]);
    gap();
    chk("stall_err", {31'd0, frame_error}, 32'd1);
    chk("stall_nothing", sb.size(), 32'd0);

    // Reset mid-word discards the partial word and clears sticky flags.
    send_zeros(32);
    for (int i = 31; i >= 22; i--) send_bit(lw[i]);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_err", {31'd0, frame_error}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    chk("mid_rst_word", led_if.led_word, 32'd0);
    send_zeros(32);
    push(32'hFF00FF00, 6'd0);
    send_word(32'hFF00FF00);
    repeat (6) @(negedge clk);
    chk("post_rst_drained", sb.size(), 32'd0);
    chk("post_rst_index", {26'd0, led_if.led_index}, 32'd0);
    chk("total_done_cnt", done_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_strip_rx.md
LED_STRIP_RX -- requirements
Module: led_strip_rx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 64, meaning LED frames per strip update (1..64).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 4096, meaning clk cycles without a strip_clk falling edge before an in-progress update is aborted.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port strip_clk, input, 1, asynchronous LED-strip serial clock.
REQ-006 SHALL have port strip_data, input, 1, asynchronous LED-strip serial data, MSB first.
REQ-007 SHALL have port led_valid, output, 1, received LED word held for consumer.
REQ-008 SHALL have port led_ready, input, 1, consumer accepts the word when high with led_valid.
REQ-009 SHALL have port led_word, output, 32, the complete received word {3'b111, brightness[4:0], blue[7:0], green[7:0], red[7:0]}.
REQ-010 SHALL have port led_index, output, 6, LED position of led_word within the update (0 = first after start frame).
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse when NUM_LEDS words of an update are received.
REQ-012 SHALL have port frame_error, output, 1, sticky malformed-update flag.
REQ-013 SHALL have port overrun, output, 1, sticky dropped-word flag.

Function
REQ-014 SHALL pass strip_clk and strip_data each through a 2-flop synchronizer plus a third delay flop (c1,c2,c3 / d1,d2,d3).
REQ-015 SHALL detect a strip bit when c2=0 and c3=1; the captured bit SHALL be d3.
REQ-016 SHALL implement FSM states HUNT, SYNC, WORD, with all state/counter updates only in bit-detect cycles except REQ-024/REQ-025.
REQ-017 HUNT: SHALL count consecutive 0 bits (6-bit saturating); a 1 bit SHALL clear the count; at the 32nd consecutive 0 SHALL go to SYNC, clear frame_error, and set the LED counter to 0.
REQ-018 SYNC: 0 bits SHALL be ignored; a 1 bit SHALL enter WORD with shift register = 1 and bit count = 1.
REQ-019 WORD: SHALL shift bits in MSB first; on the 32nd bit the word is complete.
REQ-020 On a complete word whose bits [31:29] != 3'b111: SHALL set frame_error, emit nothing, and go to HUNT with zero count 0.
REQ-021 On a valid complete word: if led_valid=0 or led_ready=1 in that cycle, SHALL load led_word/led_index (= LED counter) and assert led_valid next cycle; otherwise SHALL drop the word and set overrun.
REQ-022 After each valid word, the LED counter SHALL increment; if it reaches NUM_LEDS, frame_done SHALL pulse in the next cycle and the FSM SHALL go to HUNT with zero count 0; otherwise SHALL go to SYNC.
REQ-023 led_valid SHALL remain high and led_word/led_index stable until a cycle with led_ready=1; then led_valid SHALL clear next cycle unless a new word loads in the same cycle (REQ-021), in which case led_valid stays high with new data.
REQ-024 An idle counter SHALL clear on every bit-detect and increment otherwise while in SYNC or WORD; on reaching IDLE_TIMEOUT SHALL set frame_error and go to HUNT with zero count 0.
REQ-025 Latency: c1 first sampling strip_clk low on clk edge N SHALL give led_valid high after edge N+3 for a completing word.
REQ-026 frame_error and overrun SHALL clear only as in REQ-017 (frame_error) or by reset.
REQ-027 Leading zeros beyond 32 in HUNT/SYNC and any trailing end-frame zeros SHALL not produce words or errors.

Reset
REQ-028 Reset SHALL set state HUNT, all counters, synchronizer flops, led_word, led_index to 0, and led_valid, frame_done, frame_error, overrun to 0; a reset mid-word SHALL discard the partial word.

Verification
REQ-029 32 zeros then 0xF0000F00 -> led_valid=1, led_word=0xF0000F00, led_index=0, frame_error=0.
REQ-030 Full update of 64 words (0xF0070000), ready tied high -> 64 valid handshakes, indices 0..63, one frame_done pulse after index 63.
REQ-031 32 zeros then 0x70000000 -> no led_valid, frame_error=1; next start frame clears it.
REQ-032 led_ready held low, two valid words (0xE1000001, 0xE1000002) -> led_word stays 0xE1000001, overrun=1.
REQ-033 Strip clock stops after 10 bits of a word for IDLE_TIMEOUT cycles -> frame_error=1, state HUNT, no word emitted.
REQ-034 Reset asserted mid-word then a new start frame plus 0xFF00FF00 -> only 0xFF00FF00 emitted at index 0.
